pwm_fade_sequencer: RTL and testbench
=====================================

// Module: pwm_fade_sequencer
// PURPOSE
//  Controller that sets the duty level of the 4-bit PWM LED dimmer. Two modes:
//  MANUAL (duty follows sw) and BREATHE (auto ramp up / hold / ramp down / hold).
//  Duty is double-buffered and committed only on the dimmer's period_end pulse,
//  so the LED never sees a mid-period change. Sits between board inputs and pwm_led_dimmer.
// PARAMETERS
//  DUTY_W      4      duty/level width; MAX = 2**DUTY_W-1
//  STEP_DIV    50000  clk cycles per ramp/hold step tick (>=2)
//  HOLD_STEPS  8      ticks spent in each HOLD state; 0 = no hold
// PORTS
//  clk         in   1       system clock
//  reset       in   1       synchronous, active-high reset
//  sw          in   DUTY_W  manual duty level
//  mode_btn    in   1       debounced mode button, level; rising edge toggles mode
//  period_end  in   1       1-cycle pulse from dimmer at PWM counter wrap
//  duty        out  DUTY_W  committed duty to dimmer
//  duty_upd    out  1       1-cycle pulse, high in the cycle duty takes a new value
//  mode        out  1       0 = MANUAL, 1 = BREATHE
// BEHAVIOUR
//  - Reset: state=MANUAL, level=0, target=0, duty=0, duty_upd=0, mode=0,
//    prescaler=0, hold_cnt=0, btn_q=0. Reset mid-ramp aborts immediately.
//  - Button edge: btn_q registers mode_btn; edge = mode_btn & ~btn_q.
//    MANUAL->RAMP_UP (level starts at current sw); any BREATHE state->MANUAL.
//    Edge clears prescaler and hold_cnt. Edge and tick in same cycle: edge wins.
//  - Prescaler: counts 0..STEP_DIV-1 in BREATHE states; tick=1 at STEP_DIV-1,
//    then wraps to 0. Held at 0 in MANUAL.
//  - FSM (BREATHE), all transitions on tick:
//    RAMP_UP:   level<MAX -> level+1; level==MAX -> HOLD_HI (level kept)
//    HOLD_HI:   hold_cnt+1; hold_cnt==HOLD_STEPS-1 -> RAMP_DOWN, hold_cnt=0
//    RAMP_DOWN: level>0 -> level-1; level==0 -> HOLD_LO
//    HOLD_LO:   as HOLD_HI, exits to RAMP_UP
//    HOLD_STEPS=0: ramp end goes directly to opposite ramp on that tick.
//    level saturates; never wraps past 0 or MAX.
//  - MANUAL: level <= sw every cycle.
//  - target <= level, registered (1 cycle behind level).
//  - Commit: on period_end, if target!=duty then duty<=target, duty_upd=1 next
//    cycle; else duty unchanged, duty_upd=0. Latency period_end->duty = 1 clk.
//  - Level change coincident with period_end: commit uses pre-change target;
//    new value commits at the following period_end.
//  - No period_end ever arriving: duty holds indefinitely (no timeout).
//  - mode = (state != MANUAL), registered.
// CONFIGURATION
//  FADE_GAMMA_EN defined: target <= gamma_lut(level), a fixed perceptual
//    (approx. square-law) table, gamma(0)=0, gamma(MAX)=MAX, monotonic,
//    adds no latency (combinational LUT before target register).
//  FADE_GAMMA_EN undefined: target <= level (linear); LUT not synthesised.
//  MANUAL mode uses the same path (sw is gamma-mapped when enabled).
// TESTING  (bench: DUTY_W=4, STEP_DIV=4, HOLD_STEPS=2, gamma off unless noted)
//  1 reset asserted during RAMP_UP at level 9 -> next clk duty=0, mode=0,
//    duty_upd=0, state MANUAL.
//  2 MANUAL, sw=4'hA, pulse period_end -> duty=4'hA and duty_upd=1 one clk later;
//    second period_end with sw unchanged -> duty_upd stays 0.
//  3 sw=3, mode_btn rising -> mode=1; level 3..15 one step per 4 clk; 2 ticks
//    HOLD_HI; ramp down to 0; 2 ticks HOLD_LO; RAMP_UP again.
//  4 mode_btn rising on same cycle as tick in RAMP_UP -> level unchanged, MANUAL.
//  5 level 7->8 in same cycle as period_end -> duty=7; next period_end -> duty=8.
//  6 FADE_GAMMA_EN, MANUAL sw=0 / sw=15 -> duty 0 / 15; sw sweep 0..15 ->
//    duty non-decreasing.

Source files
------------

// File: rtl/pwm_fade_sequencer.sv
// Duty-level controller for the PWM LED dimmer: MANUAL follows sw, BREATHE ramps/holds.
// Optional FADE_GAMMA_EN maps level through a square-law LUT before the target register.
module pwm_fade_sequencer #(
    parameter int DUTY_W     = 4,
    parameter int STEP_DIV   = 50000,
    parameter int HOLD_STEPS = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] sw,
    input  logic              mode_btn,
    input  logic              period_end,
    output logic [DUTY_W-1:0] duty,
    output logic              duty_upd,
    output logic              mode
);

    localparam int PS_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int HC_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

    localparam logic [DUTY_W-1:0] LVL_MAX   = {DUTY_W{1'b1}};
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(STEP_DIV - 1);
    localparam logic [HC_W-1:0]   HOLD_LAST =
        HC_W'((HOLD_STEPS > 0) ? HOLD_STEPS - 1 : 0);
    localparam bit                NO_HOLD   = (HOLD_STEPS == 0);

    typedef enum logic [2:0] {
        S_MANUAL,
        S_RAMP_UP,
        S_HOLD_HI,
        S_RAMP_DOWN,
        S_HOLD_LO
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DUTY_W-1:0] level;
    logic [DUTY_W-1:0] level_n;
    logic [HC_W-1:0]   hold_cnt;
    logic [HC_W-1:0]   hold_n;
    logic [PS_W-1:0]   prescaler;
    logic [DUTY_W-1:0] target;
    logic [DUTY_W-1:0] mapped;
    logic              btn_q;
    logic              btn_edge;
    logic              tick;

    assign btn_edge = mode_btn & ~btn_q;
    assign tick     = (state != S_MANUAL) && (prescaler == PS_LAST);

`ifdef FADE_GAMMA_EN
    localparam int LUT_N = 2 ** DUTY_W;
    localparam int LUT_M = LUT_N - 1;

    logic [DUTY_W-1:0] gamma_lut [LUT_N];

    for (genvar i = 0; i < LUT_N; i++) begin : g_lut
        assign gamma_lut[i] = DUTY_W'((i * i + LUT_M / 2) / LUT_M);
    end

    assign mapped = gamma_lut[level];
`else
    assign mapped = level;
`endif

    // Step prescaler: free-runs only while breathing, restarted by a mode toggle
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (btn_edge || state == S_MANUAL || tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    // Mode FSM next state, level and hold counter; a button edge overrides a tick
    always_comb begin
        state_n = state;
        level_n = level;
        hold_n  = hold_cnt;
        if (btn_edge) begin
            hold_n = '0;
            if (state == S_MANUAL) begin
                state_n = S_RAMP_UP;
                level_n = sw;
            end else begin
                state_n = S_MANUAL;
            end
        end else begin
            unique case (state)
                S_MANUAL: begin
                    level_n = sw;
                end
                S_RAMP_UP: begin
                    if (tick) begin
                        if (level != LVL_MAX) begin
                            level_n = level + 1'b1;
                        end else if (NO_HOLD) begin
                            state_n = S_RAMP_DOWN;
                        end else begin
                            state_n = S_HOLD_HI;
                        end
                    end
                end
                S_HOLD_HI: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = S_RAMP_DOWN;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_cnt + 1'b1;
                        end
                    end
                end
                S_RAMP_DOWN: begin
                    if (tick) begin
                        if (level != '0) begin
                            level_n = level - 1'b1;
                        end else if (NO_HOLD) begin
                            state_n = S_RAMP_UP;
                        end else begin
                            state_n = S_HOLD_LO;
                        end
                    end
                end
                S_HOLD_LO: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state_n = S_RAMP_UP;
                            hold_n  = '0;
                        end else begin
                            hold_n = hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_n = S_MANUAL;
                end
            endcase
        end
    end

    // FSM state, level, hold counter, button history and mode flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_MANUAL;
            level    <= '0;
            hold_cnt <= '0;
            btn_q    <= 1'b0;
            mode     <= 1'b0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            hold_cnt <= hold_n;
            btn_q    <= mode_btn;
            mode     <= (state_n != S_MANUAL);
        end
    end

    // Shadow target trails level by one clock (optionally gamma-mapped)
    always_ff @(posedge clk) begin
        if (reset) begin
            target <= '0;
        end else begin
            target <= mapped;
        end
    end

    // Commit the shadow target only at the dimmer's period boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            duty     <= '0;
            duty_upd <= 1'b0;
        end else if (period_end && (target != duty)) begin
            duty     <= target;
            duty_upd <= 1'b1;
        end else begin
            duty_upd <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Scoreboard bench for pwm_fade_sequencer (DUTY_W=4, STEP_DIV=4, HOLD_STEPS=2).
// Gamma checks run only when FADE_GAMMA_EN is defined.
module tb_pwm_fade_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw;
    logic       mode_btn;
    logic       period_end;
    logic [3:0] duty;
    logic       duty_upd;
    logic       mode;

    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    int         n_upd = 0;
    bit         sb_en = 1'b1;
    logic [3:0] sb [$];
    int         upd_t [$];
    int         t_last;
    int         n0;
    int         guard;
    logic [3:0] prev;
    logic [3:0] exp_v;

    pwm_fade_sequencer #(
        .DUTY_W    (4),
        .STEP_DIV  (4),
        .HOLD_STEPS(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sw        (sw),
        .mode_btn  (mode_btn),
        .period_end(period_end),
        .duty      (duty),
        .duty_upd  (duty_upd),
        .mode      (mode)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: every duty_upd pulse pops one expected duty value
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && duty_upd) begin
                n_upd++;
                upd_t.push_back(cyc);
                if (sb_en) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_upd: duty=%0d, no update expected",
                                 duty);
                    end else begin
                        exp_v = sb.pop_front();
                        if (duty !== exp_v) begin
                            fails++;
                            $display("FAIL duty_commit: got %0d expected %0d",
                                     duty, exp_v);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (sb.size() != 0 && n < max_cyc) begin
            step(1);
            n++;
        end
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s: got %0d pending updates expected 0 after %0d cycles",
                     name, sb.size(), max_cyc);
            sb.delete();
        end
    endtask

    initial begin
        reset      = 1'b1;
        sw         = 4'd0;
        mode_btn   = 1'b0;
        period_end = 1'b0;
        step(3);
        check("reset_duty", duty, 0);
        check("reset_upd", duty_upd, 0);
        check("reset_mode", mode, 0);
        reset = 1'b0;
        step(2);

`ifdef FADE_GAMMA_EN
        sb_en      = 1'b0;
        period_end = 1'b1;
        sw = 4'd0;
        step(4);
        check("gamma_zero", duty, 0);
        sw = 4'd15;
        step(4);
        check("gamma_max", duty, 15);
        sw = 4'd0;
        step(4);
        prev = duty;
        for (int i = 0; i < 16; i++) begin
            sw = 4'(i);
            step(4);
            check("gamma_mono", (duty >= prev), 1);
            prev = duty;
        end
        period_end = 1'b0;
`else
        // manual commit and latency
        sw = 4'hA;
        step(3);
        sb.push_back(4'hA);
        period_end = 1'b1;
        step(1);
        period_end = 1'b0;
        check("upd_latency", duty_upd, 1);
        check("manual_duty", duty, 10);
        step(2);
        period_end = 1'b1;
        step(1);
        period_end = 1'b0;
        check("no_upd_same", duty_upd, 0);
        wait_drain("manual_drain", 10);

        // level change coincident with period_end
        sw = 4'd7;
        step(3);
        sw = 4'd8;
        period_end = 1'b1;
        sb.push_back(4'd7);
        step(1);
        period_end = 1'b0;
        check("coincident_old", duty, 7);
        step(3);
        sb.push_back(4'd8);
        period_end = 1'b1;
        step(1);
        period_end = 1'b0;
        check("next_commit", duty, 8);
        wait_drain("coincident_drain", 10);

        // breathe cycle with period_end held high
        sw = 4'd3;
        step(3);
        upd_t.delete();
        sb.push_back(4'd3);
        for (int v = 4; v <= 15; v++) sb.push_back(4'(v));
        for (int v = 14; v >= 0; v--) sb.push_back(4'(v));
        sb.push_back(4'd1);
        sb.push_back(4'd2);
        period_end = 1'b1;
        step(2);
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        step(1);
        check("mode_breathe", mode, 1);
        wait_drain("breathe_drain", 400);
        check("breathe_upds", upd_t.size(), 30);
        if (upd_t.size() >= 30) begin
            check("ramp_step_gap", upd_t[2] - upd_t[1], 4);
            check("hold_hi_gap", upd_t[13] - upd_t[12], 16);
            check("ramp_down_gap", upd_t[14] - upd_t[13], 4);
            check("hold_lo_gap", upd_t[28] - upd_t[27], 16);
        end

        // button edge on a ramp tick: edge wins, level stays
        t_last = upd_t[upd_t.size() - 1];
        sw     = 4'd2;
        guard  = 0;
        while (cyc < t_last + 1 && guard < 20) begin
            step(1);
            guard++;
        end
        check("tick_align", cyc, t_last + 1);
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        n0 = n_upd;
        step(1);
        check("edge_wins_mode", mode, 0);
        step(12);
        check("edge_wins_level", n_upd - n0, 0);
        check("edge_wins_duty", duty, 2);

        // reset mid-ramp
        sb.push_back(4'd9);
        sw = 4'd9;
        wait_drain("pre_reset_drain", 10);
        mode_btn = 1'b1;
        step(1);
        mode_btn = 1'b0;
        step(2);
        check("ramp_mode", mode, 1);
        sw    = 4'd0;
        reset = 1'b1;
        step(1);
        check("midramp_duty", duty, 0);
        check("midramp_mode", mode, 0);
        check("midramp_upd", duty_upd, 0);
        reset = 1'b0;
        n0 = n_upd;
        step(16);
        check("post_reset_upds", n_upd - n0, 0);
        check("post_reset_mode", mode, 0);
        period_end = 1'b0;
`endif

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
